// File: rtl/datapath.sv
// Multicycle MIPS datapath: PC, unified 256-word memory, IR/MDR, 32x32 register
// file, ALU with its control decode, and the A/B/ALUOut holding registers.
module datapath (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWriteCond,
  input  logic        PCWrite,
  input  logic        IorD,
  input  logic        R_wbar,
  input  logic        MemToReg,
  input  logic        IRWrite,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  AluOp,
  input  logic        AluSrcA,
  input  logic [1:0]  AluSrcB,
  input  logic        RegWrite,
  input  logic        RegDst,
  output logic [31:0] PCReg,
  output logic [31:0] AluOutReg,
  output logic [31:0] AReg,
  output logic [31:0] BReg,
  output logic [5:0]  Opcode
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic [31:0] mem [0:255];
  logic [31:0] r_rf [0:31];

  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;

  logic [7:0]  w_mem_idx;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_sext_imm;
  logic [31:0] w_alu_a, w_alu_b, w_alu_result, w_pc_next;
  logic        w_zero, w_pc_load;
  alu_op_t     w_alu_op;
  logic [4:0]  w_wreg;
  logic [31:0] w_wdata;

  assign w_mem_idx   = IorD ? r_aluout[9:2] : r_pc[9:2];
  assign w_mem_rdata = mem[w_mem_idx];
  assign w_sext_imm  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_wreg      = RegDst ? r_ir[15:11] : r_ir[20:16];
  assign w_wdata     = MemToReg ? r_mdr : r_aluout;

  always_comb begin
    w_alu_a = AluSrcA ? r_a : r_pc;
    case (AluSrcB)
      2'b00:   w_alu_b = r_b;
      2'b01:   w_alu_b = 32'd4;
      2'b10:   w_alu_b = w_sext_imm;
      default: w_alu_b = {w_sext_imm[29:0], 2'b00};
    endcase
  end

  // Unlisted funct codes fall back to add.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (AluOp)
      2'b00: w_alu_op = ALU_ADD;
      2'b01: w_alu_op = ALU_SUB;
      2'b11: w_alu_op = ALU_OR;
      default: begin
        case (r_ir[5:0])
          6'h22:   w_alu_op = ALU_SUB;
          6'h24:   w_alu_op = ALU_AND;
          6'h25:   w_alu_op = ALU_OR;
          6'h2A:   w_alu_op = ALU_SLT;
          default: w_alu_op = ALU_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    case (w_alu_op)
      ALU_SUB: w_alu_result = w_alu_a - w_alu_b;
      ALU_AND: w_alu_result = w_alu_a & w_alu_b;
      ALU_OR:  w_alu_result = w_alu_a | w_alu_b;
      ALU_SLT: w_alu_result = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      default: w_alu_result = w_alu_a + w_alu_b;
    endcase
  end

  assign w_zero    = (w_alu_result == 32'd0);
  assign w_pc_load = PCWrite | (PCWriteCond & w_zero);

  always_comb begin
    case (PCSrc)
      2'b01:   w_pc_next = r_aluout;
      2'b10:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      default: w_pc_next = w_alu_result;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if (w_pc_load) r_pc <= w_pc_next;
      if (IRWrite)   r_ir <= w_mem_rdata;
      r_mdr    <= w_mem_rdata;
      r_a      <= r_rf[r_ir[25:21]];
      r_b      <= r_rf[r_ir[20:16]];
      r_aluout <= w_alu_result;
    end
  end

  // Register 0 is cleared by reset and never written, so it always reads 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (RegWrite && (w_wreg != 5'd0)) begin
      r_rf[w_wreg] <= w_wdata;
    end
  end

  // Memory contents survive reset; a reset edge only suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && !R_wbar) mem[w_mem_idx] <= r_b;
  end

  assign PCReg     = r_pc;
  assign AluOutReg = r_aluout;
  assign AReg      = r_a;
  assign BReg      = r_b;
  assign Opcode    = r_ir[31:26];

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the multicycle datapath: runs lw, add, beq, sw, j and a set
// of R-type ops through hand-sequenced control words.
module tb_datapath;

  logic        clk;
  logic        rst;
  logic        pc_write_cond, pc_write, iord, r_wbar, mem_to_reg, ir_write;
  logic [1:0]  pc_src, alu_op, alu_src_b;
  logic        alu_src_a, reg_write, reg_dst;
  logic [31:0] pc_reg, aluout_reg, a_reg, b_reg;
  logic [5:0]  opcode;

  int errors = 0;
  int checks = 0;

  datapath dut (
    .CLK(clk), .RST(rst),
    .PCWriteCond(pc_write_cond), .PCWrite(pc_write), .IorD(iord), .R_wbar(r_wbar),
    .MemToReg(mem_to_reg), .IRWrite(ir_write), .PCSrc(pc_src), .AluOp(alu_op),
    .AluSrcA(alu_src_a), .AluSrcB(alu_src_b), .RegWrite(reg_write), .RegDst(reg_dst),
    .PCReg(pc_reg), .AluOutReg(aluout_reg), .AReg(a_reg), .BReg(b_reg), .Opcode(opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clr();
    pc_write_cond = 0; pc_write = 0; iord = 0; r_wbar = 1; mem_to_reg = 0;
    ir_write = 0; pc_src = 2'b00; alu_op = 2'b00; alu_src_a = 0;
    alu_src_b = 2'b00; reg_write = 0; reg_dst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    clr(); ir_write = 1; alu_src_b = 2'b01; pc_write = 1;
    tick();
  endtask

  task automatic decode();
    clr(); alu_src_b = 2'b11;
    tick();
  endtask

  logic [31:0] rtype_ir  [0:4];
  logic [31:0] rtype_exp [0:4];

  initial begin
    rtype_ir[0] = 32'h00221822; rtype_exp[0] = 32'hFFFFFFF9;  // sub 7-14
    rtype_ir[1] = 32'h00221824; rtype_exp[1] = 32'h00000006;  // and
    rtype_ir[2] = 32'h00221825; rtype_exp[2] = 32'h0000000F;  // or
    rtype_ir[3] = 32'h0022182A; rtype_exp[3] = 32'h00000001;  // slt 7<14
    rtype_ir[4] = 32'h00221827; rtype_exp[4] = 32'h00000015;  // unknown funct -> add

    dut.mem[0] = 32'h8C010010;  // lw  $1,16($0)
    dut.mem[1] = 32'h00211020;  // add $2,$1,$1
    dut.mem[2] = 32'h10210002;  // beq $1,$1,+2
    dut.mem[4] = 32'h00000007;  // data at address 16
    dut.mem[5] = 32'h10220002;  // beq $1,$2,+2
    dut.mem[6] = 32'hAC020010;  // sw  $2,16($0)
    dut.mem[7] = 32'h08000010;  // j   0x40
    for (int i = 0; i < 5; i++) dut.mem[16+i] = rtype_ir[i];

    clr();
    rst = 1;
    tick(); tick();
    chk("rst_pc", pc_reg, 32'd0);
    chk("rst_aluout", aluout_reg, 32'd0);
    chk("rst_a", a_reg, 32'd0);
    chk("rst_b", b_reg, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    rst = 0;

    // lw $1,16($0)
    fetch();
    chk("fetch1_pc", pc_reg, 32'd4);
    chk("fetch1_op", {26'd0, opcode}, 32'h23);
    decode();
    chk("dec1_aluout", aluout_reg, 32'h44);
    clr(); alu_src_a = 1; alu_src_b = 2'b10; tick();
    chk("lw_addr", aluout_reg, 32'd16);
    clr(); alu_src_a = 1; alu_src_b = 2'b10; iord = 1; tick();
    clr(); alu_src_a = 1; alu_src_b = 2'b10; mem_to_reg = 1; reg_write = 1; tick();

    // add $2,$1,$1
    fetch();
    chk("fetch2_pc", pc_reg, 32'd8);
    chk("fetch2_b_rf1", b_reg, 32'd7);
    decode();
    chk("add_a", a_reg, 32'd7);
    chk("add_b", b_reg, 32'd7);
    clr(); alu_src_a = 1; alu_op = 2'b10; tick();
    chk("add_exec", aluout_reg, 32'd14);
    clr(); alu_src_a = 1; alu_op = 2'b10; reg_dst = 1; reg_write = 1; tick();

    // beq $1,$1,+2 taken
    fetch();
    decode();
    chk("beq_target", aluout_reg, 32'd20);
    clr(); alu_src_a = 1; alu_op = 2'b01; pc_write_cond = 1; pc_src = 2'b01; tick();
    chk("beq_taken_pc", pc_reg, 32'd20);

    // beq $1,$2,+2 not taken
    fetch();
    decode();
    chk("beq2_b", b_reg, 32'd14);
    clr(); alu_src_a = 1; alu_op = 2'b01; pc_write_cond = 1; pc_src = 2'b01; tick();
    chk("beq_nt_pc", pc_reg, 32'd24);
    chk("beq_nt_sub", aluout_reg, 32'hFFFFFFF9);

    // sw $2,16($0)
    fetch();
    decode();
    clr(); alu_src_a = 1; alu_src_b = 2'b10; tick();
    chk("sw_addr", aluout_reg, 32'd16);
    chk("sw_b", b_reg, 32'd14);
    clr(); alu_src_a = 1; alu_src_b = 2'b10; iord = 1; r_wbar = 0; tick();
    chk("sw_mem", dut.mem[4], 32'd14);

    // j 0x40
    fetch();
    clr(); pc_src = 2'b10; pc_write = 1; tick();
    chk("jump_pc", pc_reg, 32'h40);

    // R-type funct decode
    for (int i = 0; i < 5; i++) begin
      fetch();
      decode();
      clr(); alu_src_a = 1; alu_op = 2'b10; tick();
      chk($sformatf("rtype%0d", i), aluout_reg, rtype_exp[i]);
    end
    chk("rtype_pc", pc_reg, 32'h54);
    clr(); alu_src_a = 1; alu_op = 2'b11; tick();
    chk("aluop_or", aluout_reg, 32'd15);

    // Asynchronous reset mid-cycle, held across edges
    clr(); ir_write = 1; alu_src_b = 2'b01; pc_write = 1;
    #3 rst = 1;
    #1;
    chk("arst_pc", pc_reg, 32'd0);
    chk("arst_aluout", aluout_reg, 32'd0);
    chk("arst_a", a_reg, 32'd0);
    chk("arst_b", b_reg, 32'd0);
    chk("arst_opcode", {26'd0, opcode}, 32'd0);
    tick(); tick();
    chk("rst_hold_pc", pc_reg, 32'd0);
    rst = 0;
    fetch();
    chk("post_rst_pc", pc_reg, 32'd4);
    chk("post_rst_op", {26'd0, opcode}, 32'h23);
    chk("post_rst_rf", dut.r_rf[1], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
